// File: rtl/accel_pkg.sv
// Register map, SPI command constants and FSM encodings for the
// accelerometer poller.
package accel_pkg;

    localparam logic [7:0] REG_WHO_AM_I = 8'h0F;
    localparam logic [7:0] REG_CTRL1    = 8'h20;
    localparam logic [7:0] REG_CTRL4    = 8'h23;
    localparam logic [7:0] REG_OUT_X    = 8'h28;
    localparam logic [7:0] REG_OUT_Y    = 8'h2A;
    localparam logic [7:0] REG_OUT_Z    = 8'h2C;

    localparam logic [7:0] SPI_RD_BIT   = 8'h80;
    localparam logic [7:0] SPI_AI_BIT   = 8'h40;

    localparam logic [7:0] CTRL1_VAL    = 8'h57;
    localparam logic [7:0] CTRL4_VAL    = 8'h88;
    localparam logic [7:0] WHO_AM_I_VAL = 8'h33;

    localparam logic [5:0] SPI_NBITS_CFG = 6'd16;

    typedef enum logic [3:0] {
        INIT,
        WHOAMI,
        CFG1,
        CFG4,
        WAIT_TICK,
        RD_X,
        RD_Y,
        RD_Z,
        PUBLISH,
        ERROR
    } state_e;

    typedef enum logic [1:0] {
        ISSUE,
        WAIT_BUSY,
        WAIT_DONE
    } sub_e;

    // Command word placed on MOSI for each transaction state
    function automatic logic [31:0] cmd_word(input state_e s);
        logic [31:0] w;
        w = 32'h0;
        case (s)
            WHOAMI: w = {16'h0, REG_WHO_AM_I | SPI_RD_BIT, 8'h00};
            CFG1:   w = {16'h0, REG_CTRL1, CTRL1_VAL};
            CFG4:   w = {16'h0, REG_CTRL4, CTRL4_VAL};
            RD_X:   w = {8'h0, REG_OUT_X | SPI_RD_BIT | SPI_AI_BIT, 16'h0};
            RD_Y:   w = {8'h0, REG_OUT_Y | SPI_RD_BIT | SPI_AI_BIT, 16'h0};
            RD_Z:   w = {8'h0, REG_OUT_Z | SPI_RD_BIT | SPI_AI_BIT, 16'h0};
            default: w = 32'h0;
        endcase
        return w;
    endfunction

    // Low byte arrives first, so it sits in miso[15:8]
    function automatic logic [15:0] axis_word(input logic [15:0] w);
        return {w[7:0], w[15:8]};
    endfunction

endpackage

// File: rtl/accel_tick.sv
// Free-running poll divider: counts 0..POLL_DIV-1 and flags the wrap
// cycle with a one-cycle tick.
module accel_tick #(
    parameter logic [31:0] POLL_DIV = 32'd120000
) (
    input  logic clk_in,
    input  logic rst_in,
    output logic tick
);

    logic [31:0] cnt;

    assign tick = (cnt == POLL_DIV - 32'd1);

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            cnt <= 32'd0;
        end else if (tick) begin
            cnt <= 32'd0;
        end else begin
            cnt <= cnt + 32'd1;
        end
    end

endmodule

// File: rtl/accel_sequencer.sv
// SPI accelerometer poller: configures the part, then reads X/Y/Z per tick.
// Optional ACCEL_WHOAMI_CHECK_EN adds the WHO_AM_I identity check.
module accel_sequencer
    import accel_pkg::*;
#(
    parameter logic [31:0] POLL_DIV     = 32'd120000,
    parameter logic [5:0]  SPI_NBITS_RD = 6'd24
) (
    input  logic        clk_in,
    input  logic        rst_in,
    output logic        spi_request,
    input  logic        spi_ready,
    output logic [31:0] spi_mosi_data,
    input  logic [31:0] spi_miso_data,
    output logic [5:0]  spi_nbits,
    output logic [15:0] accel_x,
    output logic [15:0] accel_y,
    output logic [15:0] accel_z,
    output logic        sample_valid,
    output logic        overrun,
    output logic        id_err
);

`ifdef ACCEL_WHOAMI_CHECK_EN
    localparam state_e FIRST_ST = WHOAMI;
`else
    localparam state_e FIRST_ST = CFG1;
`endif

    state_e      state;
    state_e      done_st;
    sub_e        sub;
    logic        tick;
    logic        pending;
    logic        pend_clr;
    logic        halted;
    logic [15:0] ax_q;
    logic [15:0] ay_q;
    logic [15:0] az_q;
    logic        unused_miso;

    assign unused_miso = ^spi_miso_data[31:16];

    function automatic logic [5:0] nbits_of(input state_e s);
        logic [5:0] n;
        case (s)
            WHOAMI, CFG1, CFG4: n = SPI_NBITS_CFG;
            RD_X, RD_Y, RD_Z:   n = SPI_NBITS_RD;
            default:            n = 6'd0;
        endcase
        return n;
    endfunction

    accel_tick #(
        .POLL_DIV(POLL_DIV)
    ) u_tick (
        .clk_in(clk_in),
        .rst_in(rst_in),
        .tick  (tick)
    );

    assign pend_clr = (state == WAIT_TICK) && pending;

`ifdef ACCEL_WHOAMI_CHECK_EN
    assign halted = (state == ERROR);
`else
    assign halted = 1'b0;
    assign id_err = 1'b0;
`endif

    always_comb begin
        done_st = WAIT_TICK;
        case (state)
            WHOAMI:  done_st = CFG1;
            CFG1:    done_st = CFG4;
            RD_X:    done_st = RD_Y;
            RD_Y:    done_st = RD_Z;
            RD_Z:    done_st = PUBLISH;
            default: done_st = WAIT_TICK;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state         <= INIT;
            sub           <= ISSUE;
            pending       <= 1'b0;
            overrun       <= 1'b0;
            spi_request   <= 1'b0;
            spi_mosi_data <= 32'h0;
            spi_nbits     <= 6'd0;
            ax_q          <= 16'h0;
            ay_q          <= 16'h0;
            az_q          <= 16'h0;
            accel_x       <= 16'h0;
            accel_y       <= 16'h0;
            accel_z       <= 16'h0;
            sample_valid  <= 1'b0;
`ifdef ACCEL_WHOAMI_CHECK_EN
            id_err        <= 1'b0;
`endif
        end else begin
            spi_request  <= 1'b0;
            sample_valid <= 1'b0;

            // A tick racing the clear keeps the flag set without overrun
            if (!halted) begin
                if (tick) begin
                    if (pending && !pend_clr) begin
                        overrun <= 1'b1;
                    end
                    pending <= 1'b1;
                end else if (pend_clr) begin
                    pending <= 1'b0;
                end
            end

            case (state)
                INIT: begin
                    state         <= FIRST_ST;
                    sub           <= ISSUE;
                    spi_mosi_data <= cmd_word(FIRST_ST);
                    spi_nbits     <= nbits_of(FIRST_ST);
                end
                WAIT_TICK: begin
                    if (pending) begin
                        state         <= RD_X;
                        sub           <= ISSUE;
                        spi_mosi_data <= cmd_word(RD_X);
                        spi_nbits     <= nbits_of(RD_X);
                    end
                end
                PUBLISH: begin
                    accel_x      <= ax_q;
                    accel_y      <= ay_q;
                    accel_z      <= az_q;
                    sample_valid <= 1'b1;
                    state        <= WAIT_TICK;
                end
`ifdef ACCEL_WHOAMI_CHECK_EN
                ERROR: begin
                    state <= ERROR;
                end
`endif
                default: begin
                    case (sub)
                        ISSUE: begin
                            if (spi_ready) begin
                                spi_request <= 1'b1;
                                sub         <= WAIT_BUSY;
                            end
                        end
                        WAIT_BUSY: begin
                            if (!spi_ready) begin
                                sub <= WAIT_DONE;
                            end
                        end
                        default: begin
                            if (spi_ready) begin
                                case (state)
                                    RD_X: ax_q <= axis_word(spi_miso_data[15:0]);
                                    RD_Y: ay_q <= axis_word(spi_miso_data[15:0]);
                                    RD_Z: az_q <= axis_word(spi_miso_data[15:0]);
                                    default: ;
                                endcase
`ifdef ACCEL_WHOAMI_CHECK_EN
                                if (state == WHOAMI &&
                                    spi_miso_data[7:0] != WHO_AM_I_VAL) begin
                                    id_err <= 1'b1;
                                    state  <= ERROR;
                                end else begin
                                    state         <= done_st;
                                    sub           <= ISSUE;
                                    spi_mosi_data <= cmd_word(done_st);
                                    spi_nbits     <= nbits_of(done_st);
                                end
`else
                                state         <= done_st;
                                sub           <= ISSUE;
                                spi_mosi_data <= cmd_word(done_st);
                                spi_nbits     <= nbits_of(done_st);
`endif
                            end
                        end
                    endcase
                end
            endcase
        end
    end

endmodule
